// File: rtl/alu_arbiter_pkg.sv
// Shared definitions for alu_arbiter: ALU function codes, error codes,
// arbiter FSM states and the grant-lock record.
package alu_arbiter_pkg;

    typedef enum logic [3:0] {
        OP_NOCHANGE = 4'b0000,
        OP_ADD      = 4'b0001,
        OP_SUB      = 4'b0010,
        OP_LOAD     = 4'b0100,
        OP_NOT      = 4'b0101,
        OP_AND      = 4'b0110,
        OP_OR       = 4'b0111,
        OP_XOR      = 4'b1000,
        OP_SHL      = 4'b1001,
        OP_SHR      = 4'b1010
    } alu_op_e;

    localparam logic [1:0] ERR_NONE      = 2'b00;
    localparam logic [1:0] ERR_OVERFLOW  = 2'b01;
    localparam logic [1:0] ERR_UNDERFLOW = 2'b10;

    localparam int NUM_REQ = 2;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_RESP
    } state_e;

    typedef struct packed {
        logic active;
        logic owner;
    } lock_t;

    // While a lock is held only its owner may be granted.
    function automatic logic [NUM_REQ-1:0] elig_mask(lock_t l);
        if (!l.active) return 2'b11;
        return l.owner ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/alu_arbiter_rr_grant2.sv
// Two-way round-robin grant: among valid & eligible requesters, a tie goes to
// the one that was not served last.
module rr_grant2 (
    input  logic [1:0] valid,
    input  logic [1:0] elig,
    input  logic       last,
    output logic [1:0] grant,
    output logic       idx
);

    logic [1:0] cand;

    always_comb begin
        cand  = valid & elig;
        grant = 2'b00;
        idx   = 1'b0;
        if (cand == 2'b11) begin
            idx   = ~last;
            grant = last ? 2'b01 : 2'b10;
        end else if (cand[1]) begin
            idx   = 1'b1;
            grant = 2'b10;
        end else if (cand[0]) begin
            grant = 2'b01;
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// Two-requester arbiter in front of a shared accumulator ALU: accept, issue
// one cycle, capture the ALU result, hold the response until taken.
// ALU_ARBITER_LOCK_EN: a command with lock=1 reserves the ALU for its owner.
module alu_arbiter
    import alu_arbiter_pkg::*;
#(
    parameter int datalen  = 8,
    parameter int modelen  = 4,
    parameter int errorlen = 2
) (
    input  logic                clk,
    input  logic                reset,

    input  logic                req0_valid,
    output logic                req0_ready,
    input  logic [modelen-1:0]  req0_mode,
    input  logic [datalen-1:0]  req0_a,
    input  logic [datalen-1:0]  req0_b,
    input  logic                req0_clear,
    input  logic                req0_lock,

    input  logic                req1_valid,
    output logic                req1_ready,
    input  logic [modelen-1:0]  req1_mode,
    input  logic [datalen-1:0]  req1_a,
    input  logic [datalen-1:0]  req1_b,
    input  logic                req1_clear,
    input  logic                req1_lock,

    output logic                rsp0_valid,
    input  logic                rsp0_ready,
    output logic [datalen-1:0]  rsp0_result,
    output logic [errorlen-1:0] rsp0_error,

    output logic                rsp1_valid,
    input  logic                rsp1_ready,
    output logic [datalen-1:0]  rsp1_result,
    output logic [errorlen-1:0] rsp1_error,

    output logic [modelen-1:0]  alu_mode,
    output logic [datalen-1:0]  alu_inA,
    output logic [datalen-1:0]  alu_inB,
    output logic                alu_clear,
    input  logic [datalen-1:0]  alu_out,
    input  logic [errorlen-1:0] alu_error
);

    state_e state, nxt;

    logic [NUM_REQ-1:0]                vld, rdy, grant, elig, rsp_rdy, rsp_vld;
    logic                              gidx, last, owner, accept;
    logic [NUM_REQ-1:0][modelen-1:0]   req_mode;
    logic [NUM_REQ-1:0][datalen-1:0]   req_a, req_b;
    logic [NUM_REQ-1:0]                req_clear, req_lock;

    logic [modelen-1:0]                l_mode;
    logic [datalen-1:0]                l_a, l_b;
    logic                              l_clear, l_lock;
    logic [NUM_REQ-1:0][datalen-1:0]   rsp_res;
    logic [NUM_REQ-1:0][errorlen-1:0]  rsp_err;

    assign vld       = {req1_valid, req0_valid};
    assign rsp_rdy   = {rsp1_ready, rsp0_ready};
    assign req_mode  = {req1_mode, req0_mode};
    assign req_a     = {req1_a, req0_a};
    assign req_b     = {req1_b, req0_b};
    assign req_clear = {req1_clear, req0_clear};
    assign req_lock  = {req1_lock, req0_lock};

`ifdef ALU_ARBITER_LOCK_EN
    lock_t lock;

    // The lock follows the flag of each completed command, so the owner
    // releases it simply by finishing a command with lock=0.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            lock <= '0;
        else if (state == S_RESP && rsp_rdy[owner])
            lock <= '{active: l_lock, owner: owner};
    end

    assign elig = elig_mask(lock);
`else
    logic unused_lock;
    assign unused_lock = l_lock;
    assign elig        = 2'b11;
`endif

    rr_grant2 u_grant (
        .valid (vld),
        .elig  (elig),
        .last  (last),
        .grant (grant),
        .idx   (gidx)
    );

    assign accept = (state == S_IDLE) && !reset && |grant;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= S_IDLE;
        else       state <= nxt;
    end

    always_comb begin
        nxt = state;
        unique case (state)
            S_IDLE:  if (accept) nxt = S_ISSUE;
            S_ISSUE: nxt = S_WAIT;
            S_WAIT:  nxt = S_RESP;
            S_RESP:  if (rsp_rdy[owner]) nxt = S_IDLE;
            default: nxt = S_IDLE;
        endcase
    end

    always_comb begin
        // Ready only for the requester that would win, so a handshake never drops a command.
        rdy       = (state == S_IDLE && !reset) ? grant : 2'b00;
        rsp_vld   = 2'b00;
        alu_mode  = '0;
        alu_inA   = '0;
        alu_inB   = '0;
        alu_clear = 1'b0;
        if (state == S_RESP) rsp_vld[owner] = 1'b1;
        if (state == S_ISSUE) begin
            alu_mode  = l_mode;
            alu_inA   = l_a;
            alu_inB   = l_b;
            alu_clear = l_clear;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last    <= 1'b1;
            owner   <= 1'b0;
            l_mode  <= '0;
            l_a     <= '0;
            l_b     <= '0;
            l_clear <= 1'b0;
            l_lock  <= 1'b0;
            rsp_res <= '0;
            rsp_err <= '0;
        end else begin
            if (accept) begin
                owner   <= gidx;
                last    <= gidx;
                l_mode  <= req_mode[gidx];
                l_a     <= req_a[gidx];
                l_b     <= req_b[gidx];
                l_clear <= req_clear[gidx];
                l_lock  <= req_lock[gidx];
            end
            if (state == S_WAIT) begin
                rsp_res[owner] <= alu_out;
                rsp_err[owner] <= alu_error;
            end
        end
    end

    assign req0_ready  = rdy[0];
    assign req1_ready  = rdy[1];
    assign rsp0_valid  = rsp_vld[0];
    assign rsp1_valid  = rsp_vld[1];
    assign rsp0_result = rsp_res[0];
    assign rsp1_result = rsp_res[1];
    assign rsp0_error  = rsp_err[0];
    assign rsp1_error  = rsp_err[1];

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter with a behavioural accumulator ALU.
// Lock expectations follow ALU_ARBITER_LOCK_EN.
module tb_alu_arbiter;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [1:0] req_valid = 2'b00;
    logic [1:0] req_ready;
    logic [3:0] req_mode [2];
    logic [7:0] req_a [2];
    logic [7:0] req_b [2];
    logic [1:0] req_clear = 2'b00;
    logic [1:0] req_lock = 2'b00;
    logic [1:0] rsp_valid;
    logic [1:0] rsp_ready = 2'b11;
    logic [7:0] rsp_result [2];
    logic [1:0] rsp_error [2];
    logic [3:0] alu_mode;
    logic [7:0] alu_inA, alu_inB, acc;
    logic       alu_clear;
    logic [1:0] aerr;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    alu_arbiter dut (
        .clk(clk), .reset(reset),
        .req0_valid(req_valid[0]), .req0_ready(req_ready[0]), .req0_mode(req_mode[0]),
        .req0_a(req_a[0]), .req0_b(req_b[0]), .req0_clear(req_clear[0]), .req0_lock(req_lock[0]),
        .req1_valid(req_valid[1]), .req1_ready(req_ready[1]), .req1_mode(req_mode[1]),
        .req1_a(req_a[1]), .req1_b(req_b[1]), .req1_clear(req_clear[1]), .req1_lock(req_lock[1]),
        .rsp0_valid(rsp_valid[0]), .rsp0_ready(rsp_ready[0]),
        .rsp0_result(rsp_result[0]), .rsp0_error(rsp_error[0]),
        .rsp1_valid(rsp_valid[1]), .rsp1_ready(rsp_ready[1]),
        .rsp1_result(rsp_result[1]), .rsp1_error(rsp_error[1]),
        .alu_mode(alu_mode), .alu_inA(alu_inA), .alu_inB(alu_inB), .alu_clear(alu_clear),
        .alu_out(acc), .alu_error(aerr)
    );

    // Accumulator ALU: clear zeroes the base before the operation is applied.
    function automatic logic [9:0] alu_f(input logic [3:0] m, input logic [7:0] cur,
                                         input logic [7:0] a, input logic clr);
        logic [7:0] base;
        logic [8:0] w;
        logic [1:0] e;
        base = clr ? 8'h00 : cur;
        w    = {1'b0, base};
        e    = 2'b00;
        case (m)
            4'b0100: w = {1'b0, a};
            4'b0101: w = {1'b0, ~a};
            4'b0001: begin w = {1'b0, base} + {1'b0, a}; if (w[8]) e = 2'b01; end
            4'b0010: begin w = {1'b0, base} - {1'b0, a}; if (w[8]) e = 2'b10; end
            4'b0110: w = {1'b0, base & a};
            4'b0111: w = {1'b0, base | a};
            4'b1000: w = {1'b0, base ^ a};
            4'b1001: w = {1'b0, base[6:0], 1'b0};
            4'b1010: w = {2'b00, base[7:1]};
            default: ;
        endcase
        return {e, w[7:0]};
    endfunction

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc  <= 8'h00;
            aerr <= 2'b00;
        end else if (alu_clear || alu_mode != 4'b0000) begin
            {aerr, acc} <= alu_f(alu_mode, acc, alu_inA, alu_clear);
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic issue(input int n, input logic [3:0] mode, input logic [7:0] a,
                         input logic [7:0] b, input logic clr, input logic lk);
        req_mode[n]  = mode;
        req_a[n]     = a;
        req_b[n]     = b;
        req_clear[n] = clr;
        req_lock[n]  = lk;
        req_valid[n] = 1'b1;
    endtask

    // Waits for requester n's grant, then follows the command through
    // ISSUE/WAIT/RESP; hold > 0 keeps rsp_ready low for that many extra cycles.
    task automatic serve(input int n, input logic [3:0] mode, input logic [7:0] a,
                         input logic [7:0] b, input logic clr, input logic [7:0] res,
                         input logic [1:0] err, input int hold);
        bit got = 0;
        rsp_ready[n] = (hold == 0);
        for (int k = 0; k < 16 && !got; k++) begin
            #1;
            if (req_ready[n]) got = 1;
            else @(negedge clk);
        end
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL grant_timeout: req%0d ready never seen, expected 1", n);
            req_valid[n] = 1'b0;
            rsp_ready[n] = 1'b1;
            return;
        end
        check("other_ready_low", req_ready[1-n], 0);
        @(posedge clk);
        @(negedge clk);
        req_valid[n] = 1'b0;
        check("issue_mode", alu_mode, mode);
        check("issue_inA", alu_inA, a);
        check("issue_inB", alu_inB, b);
        check("issue_clear", alu_clear, clr);
        check("issue_ready_low", req_ready, 2'b00);
        @(negedge clk);
        check("wait_mode_idle", alu_mode, 4'b0000);
        check("wait_clear_low", alu_clear, 0);
        check("wait_rsp_not_yet", rsp_valid[n], 0);
        @(negedge clk);
        check("rsp_valid", rsp_valid[n], 1);
        check("rsp_other_low", rsp_valid[1-n], 0);
        check("rsp_result", rsp_result[n], res);
        check("rsp_error", rsp_error[n], err);
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            check("bp_valid_held", rsp_valid[n], 1);
            check("bp_result_stable", rsp_result[n], res);
            check("bp_error_stable", rsp_error[n], err);
            check("bp_ready_low", req_ready, 2'b00);
        end
        rsp_ready[n] = 1'b1;
        @(negedge clk);
        check("rsp_done", rsp_valid[n], 0);
    endtask

    typedef struct {
        int         n;
        logic [3:0] mode;
        logic [7:0] a;
        logic [7:0] b;
        logic       clr;
        logic [7:0] res;
        logic [1:0] err;
    } vec_t;

    vec_t tbl[12];

    initial begin
        tbl[0]  = '{0, 4'b0100, 8'h51, 8'h00, 1'b0, 8'h51, 2'b00};
        tbl[1]  = '{1, 4'b0001, 8'h20, 8'h11, 1'b0, 8'h71, 2'b00};
        tbl[2]  = '{0, 4'b0001, 8'hA0, 8'h22, 1'b0, 8'h11, 2'b01};
        tbl[3]  = '{1, 4'b0010, 8'h20, 8'h33, 1'b0, 8'hF1, 2'b10};
        tbl[4]  = '{0, 4'b0110, 8'h3C, 8'h44, 1'b0, 8'h30, 2'b00};
        tbl[5]  = '{1, 4'b0111, 8'h05, 8'h55, 1'b0, 8'h35, 2'b00};
        tbl[6]  = '{0, 4'b1000, 8'hFF, 8'h66, 1'b0, 8'hCA, 2'b00};
        tbl[7]  = '{1, 4'b1001, 8'h00, 8'h77, 1'b0, 8'h94, 2'b00};
        tbl[8]  = '{0, 4'b1010, 8'h00, 8'h88, 1'b0, 8'h4A, 2'b00};
        tbl[9]  = '{1, 4'b0000, 8'h00, 8'h00, 1'b1, 8'h00, 2'b00};
        tbl[10] = '{0, 4'b0101, 8'h0F, 8'h99, 1'b0, 8'hF0, 2'b00};
        tbl[11] = '{1, 4'b1000, 8'h0F, 8'hAA, 1'b0, 8'hFF, 2'b00};

        for (int i = 0; i < 2; i++) begin
            req_mode[i] = 4'h0;
            req_a[i]    = 8'h00;
            req_b[i]    = 8'h00;
        end

        // Reset state, with both requesters asking.
        req_valid = 2'b11;
        repeat (2) @(negedge clk);
        check("reset_ready", req_ready, 2'b00);
        check("reset_rsp_valid", rsp_valid, 2'b00);
        check("reset_alu_mode", alu_mode, 4'b0000);
        check("reset_alu_clear", alu_clear, 0);
        check("reset_rsp0_result", rsp_result[0], 8'h00);
        check("reset_rsp1_error", rsp_error[1], 2'b00);
        req_valid = 2'b00;
        reset = 1'b0;
        @(negedge clk);

        // First tie after reset goes to req0.
        issue(0, 4'b0100, 8'h0F, 8'h00, 1'b0, 1'b0);
        issue(1, 4'b0101, 8'h0F, 8'h00, 1'b0, 1'b0);
        #1;
        check("tie_ready", req_ready, 2'b01);
        serve(0, 4'b0100, 8'h0F, 8'h00, 1'b0, 8'h0F, 2'b00, 0);
        serve(1, 4'b0101, 8'h0F, 8'h00, 1'b0, 8'hF0, 2'b00, 0);

        for (int i = 0; i < 12; i++) begin
            issue(tbl[i].n, tbl[i].mode, tbl[i].a, tbl[i].b, tbl[i].clr, 1'b0);
            serve(tbl[i].n, tbl[i].mode, tbl[i].a, tbl[i].b, tbl[i].clr,
                  tbl[i].res, tbl[i].err, 0);
        end

        // Back-pressure on req0 while req1 waits.
        issue(0, 4'b0100, 8'h5A, 8'h00, 1'b0, 1'b0);
        issue(1, 4'b0100, 8'hA5, 8'h00, 1'b0, 1'b0);
        serve(0, 4'b0100, 8'h5A, 8'h00, 1'b0, 8'h5A, 2'b00, 5);
        serve(1, 4'b0100, 8'hA5, 8'h00, 1'b0, 8'hA5, 2'b00, 0);

        // Lock: req0 locks, req1 keeps asking, req0 follows with an unlocked op.
        issue(0, 4'b0100, 8'h10, 8'h00, 1'b0, 1'b1);
        issue(1, 4'b0101, 8'h33, 8'h00, 1'b0, 1'b0);
        serve(0, 4'b0100, 8'h10, 8'h00, 1'b0, 8'h10, 2'b00, 0);
        issue(0, 4'b0101, 8'h10, 8'h00, 1'b0, 1'b0);
        #1;
`ifdef ALU_ARBITER_LOCK_EN
        check("lock_ready", req_ready, 2'b01);
        serve(0, 4'b0101, 8'h10, 8'h00, 1'b0, 8'hEF, 2'b00, 0);
        serve(1, 4'b0101, 8'h33, 8'h00, 1'b0, 8'hCC, 2'b00, 0);
`else
        check("nolock_ready", req_ready, 2'b10);
        serve(1, 4'b0101, 8'h33, 8'h00, 1'b0, 8'hCC, 2'b00, 0);
        serve(0, 4'b0101, 8'h10, 8'h00, 1'b0, 8'hEF, 2'b00, 0);
`endif

        // Reset during WAIT drops the command.
        issue(0, 4'b0100, 8'h77, 8'h00, 1'b0, 1'b0);
        #1;
        check("midrst_grant", req_ready[0], 1);
        @(posedge clk);
        @(negedge clk);
        req_valid[0] = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("midrst_alu_mode", alu_mode, 4'b0000);
        check("midrst_rsp_valid", rsp_valid, 2'b00);
        check("midrst_ready", req_ready, 2'b00);
        @(negedge clk);
        reset = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("midrst_no_rsp", rsp_valid, 2'b00);
        end

        // After reset req0 wins the tie again.
        issue(1, 4'b0100, 8'h22, 8'h00, 1'b0, 1'b0);
        issue(0, 4'b0100, 8'h33, 8'h00, 1'b0, 1'b0);
        serve(0, 4'b0100, 8'h33, 8'h00, 1'b0, 8'h33, 2'b00, 0);
        serve(1, 4'b0100, 8'h22, 8'h00, 1'b0, 8'h22, 2'b00, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 SHALL have parameter datalen, default 8, operand/result width.
REQ-002 SHALL have parameter modelen, default 4, function-code width.
REQ-003 SHALL have parameter errorlen, default 2, error-code width.
REQ-004 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-006 SHALL have ports reqN_valid / reqN_ready (N=0,1)  input / output  1  command handshake per requester.
REQ-007 SHALL have ports reqN_mode  input  modelen  function code; reqN_a, reqN_b  input  datalen  operands.
REQ-008 SHALL have ports reqN_clear, reqN_lock  input  1  clear-accumulator and hold-grant flags.
REQ-009 SHALL have ports rspN_valid  output  1; rspN_ready  input  1; rspN_result  output  datalen; rspN_error  output  errorlen.
REQ-010 SHALL have ports alu_mode  output  modelen; alu_inA, alu_inB  output  datalen; alu_clear  output  1  drive to ALU.
REQ-011 SHALL have ports alu_out  input  datalen; alu_error  input  errorlen  ALU accumulator and error.

Function
REQ-012 SHALL implement FSM IDLE -> ISSUE -> WAIT -> RESP -> IDLE.
REQ-013 IDLE: reqN_ready = 1 only for eligible requesters; accept on valid&ready at edge t; latch mode/a/b/clear/lock/owner; go ISSUE.
REQ-014 ISSUE (one cycle): drive latched mode/operands; alu_clear = latched clear; ALU captures at edge t+1; go WAIT.
REQ-015 WAIT (one cycle): at edge t+2 register alu_out/alu_error into rsp regs of owner; go RESP.
REQ-016 RESP: rspOwner_valid = 1 from edge t+2 until rspOwner_ready sampled high; then IDLE. Min accept-to-accept: 4 cycles.
REQ-017 Outside ISSUE: alu_mode = 4'b0000 (NoChange), alu_clear = 0, alu_inA/alu_inB = 0; accumulator holds.
REQ-018 Round-robin: both valid in IDLE -> grant requester not served last; single valid -> grant it.
REQ-019 reqN_ready SHALL be 0 in ISSUE, WAIT, RESP; non-owner rsp_valid always 0.
REQ-020 rspN_result/rspN_error SHALL stay stable while rspN_valid high and ready low.
REQ-021 Error code SHALL pass through unmodified (00 none, 01 overflow, 10 underflow).

Reset
REQ-022 reset high: state IDLE, all reqN_ready 0 during reset, rspN_valid 0, rsp regs 0, alu_mode 0000, alu_clear 0, last-served = 1 (req0 wins first tie), lock cleared.
REQ-023 reset mid-operation SHALL drop the in-flight command with no response.

Configuration
REQ-024 Macro ALU_ARBITER_LOCK_EN defined: command accepted with reqN_lock=1 makes only requester N eligible after its response completes, until N completes a command with lock=0.
REQ-025 Macro ALU_ARBITER_LOCK_EN undefined: reqN_lock ignored; pure round-robin.

Structure
REQ-026 Shared package SHALL hold function codes (NoChange, Load, NOT, AND, OR, XOR, Add, Subtract, ShiftLeft, ShiftRight), error codes, FSM state enum.
REQ-027 Sub-module rr_grant2 SHALL compute 2-way round-robin grant from valids, eligibility mask, last-served.

Verification
REQ-028 req0 only: Load a=0x51 -> alu_mode 0100 one cycle; rsp0_valid at t+2, result 0x51, error 00.
REQ-029 Both valid after reset: req0 Load 0x0F, req1 NOT a=0x0F -> req0 served first, then req1; rsp1_result 0xF0.
REQ-030 Back-pressure: rsp0_ready low 5 cycles -> rsp0_valid/result held stable; req1 ready stays 0.
REQ-031 Lock (macro on): req0 lock=1 Load 0x10, req1 valid continuously, req0 next op lock=0 NOT -> req1 granted only after second req0 response; macro off -> req1 granted after first.
REQ-032 Reset asserted during WAIT -> next cycle IDLE, rsp0_valid 0, alu_mode 0000, no response issued.
REQ-033 reqN_clear=1 with NoChange -> alu_clear high one cycle; rsp result 0x00.
